// File: rtl/mpf_vtp_pkg.sv
// Shared VTP types for the page-table walk path and a small round-robin helper.
package mpf_vtp_pkg;
  typedef logic [35:0] t_tlb_4kb_va_page_idx;
  typedef logic [35:0] t_tlb_4kb_pa_page_idx;
  typedef logic [7:0]  t_mpf_vtp_pt_walk_meta;
  typedef logic [7:0]  t_mpf_vtp_req_tag;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Small distributed-RAM FIFO with a combinational head (valid in the same cycle as notEmpty).
module cci_mpf_prim_fifo_lutram #(
  parameter int N_DATA_BITS     = 32,
  parameter int N_ENTRIES       = 2,
  parameter int REGISTER_OUTPUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic                   enq_en,
  output logic                   not_full,
  output logic [N_DATA_BITS-1:0] first,
  input  logic                   deq_en,
  output logic                   not_empty
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int CW = $clog2(N_ENTRIES + 1);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  // Only the unregistered head is provided; the option is accepted for interface compatibility.
  if (REGISTER_OUTPUT != 0) begin : g_reg_out
  end

  assign not_full  = (cnt != CW'(N_ENTRIES));
  assign not_empty = (cnt != '0);
  assign first     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq_en) mem[wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_en) wr_ptr <= (wr_ptr == AW'(N_ENTRIES - 1)) ? '0 : wr_ptr + AW'(1);
      if (deq_en) rd_ptr <= (rd_ptr == AW'(N_ENTRIES - 1)) ? '0 : rd_ptr + AW'(1);
      cnt <= cnt + CW'(enq_en) - CW'(deq_en);
    end
  end
endmodule

// File: rtl/mpf_vtp_pt_walk_arb_pick.sv
// Combinational round-robin picker: first set request at or after ptr, searching cyclically.
module mpf_vtp_pt_walk_arb_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);
  logic [2*N-1:0] rot;

  always_comb begin
    any = 1'b0;
    idx = '0;
    rot = {req, req} >> ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/mpf_svc_vtp_pt_walk_arb.sv
// Shares one in-order VTP page-table walk server among N_CLIENTS requesters;
// a FIFO of client indices routes each in-order response back to its issuer.
module mpf_svc_vtp_pt_walk_arb
  import mpf_vtp_pkg::*;
#(
  parameter int N_CLIENTS       = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DEBUG_MESSAGES  = 0
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                  [N_CLIENTS-1:0]        c_req_en,
  output logic                  [N_CLIENTS-1:0]        c_req_rdy,
  input  t_tlb_4kb_va_page_idx  [N_CLIENTS-1:0]        c_req_va,
  input  t_mpf_vtp_pt_walk_meta [N_CLIENTS-1:0]        c_req_meta,
  input  logic                  [N_CLIENTS-1:0]        c_req_spec,
  input  t_mpf_vtp_req_tag      [N_CLIENTS-1:0]        c_req_tag,
  output logic                  [N_CLIENTS-1:0]        c_rsp_en,
  output t_tlb_4kb_pa_page_idx                         c_rsp_pa,
  output t_tlb_4kb_va_page_idx                         c_rsp_va,
  output t_mpf_vtp_pt_walk_meta                        c_rsp_meta,
  output t_mpf_vtp_req_tag                             c_rsp_tag,
  output logic                                         c_rsp_spec,
  output logic                                         c_rsp_big,
  output logic                                         c_rsp_notpresent,
  output logic                                         s_req_en,
  input  logic                                         s_req_rdy,
  output t_tlb_4kb_va_page_idx                         s_req_va,
  output t_mpf_vtp_pt_walk_meta                        s_req_meta,
  output logic                                         s_req_spec,
  output t_mpf_vtp_req_tag                             s_req_tag,
  input  logic                                         s_rsp_en,
  input  t_tlb_4kb_pa_page_idx                         s_rsp_pa,
  input  t_tlb_4kb_va_page_idx                         s_rsp_va,
  input  t_mpf_vtp_pt_walk_meta                        s_rsp_meta,
  input  t_mpf_vtp_req_tag                             s_rsp_tag,
  input  logic                                         s_rsp_spec,
  input  logic                                         s_rsp_big,
  input  logic                                         s_rsp_notpresent,
  output logic                                         busy,
  output logic                                         route_err
);
  localparam int IW = $clog2(N_CLIENTS);
  typedef logic [IW-1:0] t_mpf_vtp_pt_client_idx;

  if (DEBUG_MESSAGES != 0) begin : g_debug
  end

  logic                  [N_CLIENTS-1:0] slot_vld, slot_spec;
  t_tlb_4kb_va_page_idx  [N_CLIENTS-1:0] slot_va;
  t_mpf_vtp_pt_walk_meta [N_CLIENTS-1:0] slot_meta;
  t_mpf_vtp_req_tag      [N_CLIENTS-1:0] slot_tag;

  t_mpf_vtp_pt_client_idx rr_ns, rr_sp, ns_idx, sp_idx, win, head;
  logic ns_any, sp_any, grant, fifo_not_full, fifo_not_empty, deq;

  assign c_req_rdy = ~slot_vld;

  mpf_vtp_pt_walk_arb_pick #(.N(N_CLIENTS)) pick_ns (
    .req(slot_vld & ~slot_spec), .ptr(rr_ns), .any(ns_any), .idx(ns_idx)
  );
  mpf_vtp_pt_walk_arb_pick #(.N(N_CLIENTS)) pick_sp (
    .req(slot_vld & slot_spec), .ptr(rr_sp), .any(sp_any), .idx(sp_idx)
  );

  // Speculative slots only compete when no non-speculative slot is waiting.
  assign win   = ns_any ? ns_idx : sp_idx;
  assign grant = (ns_any | sp_any) & s_req_rdy & fifo_not_full;
  assign deq   = s_rsp_en & fifo_not_empty;
  assign busy  = fifo_not_empty;

  cci_mpf_prim_fifo_lutram #(
    .N_DATA_BITS(IW), .N_ENTRIES(MAX_OUTSTANDING), .REGISTER_OUTPUT(0)
  ) route_fifo (
    .clk(clk), .reset(reset),
    .enq_data(win), .enq_en(grant), .not_full(fifo_not_full),
    .first(head), .deq_en(deq), .not_empty(fifo_not_empty)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (c_req_en[i]) begin
        slot_va[i]   <= c_req_va[i];
        slot_meta[i] <= c_req_meta[i];
        slot_spec[i] <= c_req_spec[i];
        slot_tag[i]  <= c_req_tag[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld <= '0;
      rr_ns    <= '0;
      rr_sp    <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (grant && win == IW'(i)) slot_vld[i] <= 1'b0;
        if (c_req_en[i])            slot_vld[i] <= 1'b1;
      end
      if (grant && ns_any)  rr_ns <= IW'(rr_next(int'(win), N_CLIENTS));
      if (grant && !ns_any) rr_sp <= IW'(rr_next(int'(win), N_CLIENTS));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_req_en   <= 1'b0;
      s_req_va   <= '0;
      s_req_meta <= '0;
      s_req_spec <= 1'b0;
      s_req_tag  <= '0;
    end else begin
      s_req_en <= grant;
      if (grant) begin
        s_req_va   <= slot_va[win];
        s_req_meta <= slot_meta[win];
        s_req_spec <= slot_spec[win];
        s_req_tag  <= slot_tag[win];
      end
    end
  end

  // Responses with no recorded issuer are dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_rsp_en         <= '0;
      c_rsp_pa         <= '0;
      c_rsp_va         <= '0;
      c_rsp_meta       <= '0;
      c_rsp_tag        <= '0;
      c_rsp_spec       <= 1'b0;
      c_rsp_big        <= 1'b0;
      c_rsp_notpresent <= 1'b0;
      route_err        <= 1'b0;
    end else begin
      c_rsp_en <= deq ? (N_CLIENTS'(1) << head) : '0;
      if (s_rsp_en) begin
        c_rsp_pa         <= s_rsp_pa;
        c_rsp_va         <= s_rsp_va;
        c_rsp_meta       <= s_rsp_meta;
        c_rsp_tag        <= s_rsp_tag;
        c_rsp_spec       <= s_rsp_spec;
        c_rsp_big        <= s_rsp_big;
        c_rsp_notpresent <= s_rsp_notpresent;
        if (!fifo_not_empty) route_err <= 1'b1;
      end
    end
  end
endmodule
